// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants, state/mode encodings and the round leaf functions
// used by the SHA-224/SHA-256 compression engine.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUT    = 2'd3
    } sha2_state_e;

    typedef enum logic {
        MODE_SHA256 = 1'b0,
        MODE_SHA224 = 1'b1
    } sha2_mode_e;

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sha2_k(input logic [5:0] t);
        return K_TABLE[t];
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sha2_ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] sha2_maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 round: working variables a..h (index 0 = a) in,
// next working variables out.
module sha2_round
(
    input  logic [7:0][31:0] state_i,
    input  logic [31:0]      k_i,
    input  logic [31:0]      w_i,
    output logic [7:0][31:0] state_o
);
    import sha2_pkg::*;

    logic [31:0] temp1;
    logic [31:0] temp2;

    always_comb begin
        temp1 = state_i[7] + big_sigma1(state_i[4])
              + sha2_ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
        temp2 = big_sigma0(state_i[0]) + sha2_maj(state_i[0], state_i[1], state_i[2]);

        state_o[0] = temp1 + temp2;
        state_o[1] = state_i[0];
        state_o[2] = state_i[1];
        state_o[3] = state_i[2];
        state_o[4] = state_i[3] + temp1;
        state_o[5] = state_i[4];
        state_o[6] = state_i[5];
        state_o[7] = state_i[6];
    end

endmodule

// File: rtl/sha2_compress.sv
// Multi-block SHA-224/SHA-256 compression engine: one schedule word per round,
// hash chaining across blocks, and a valid/ready digest stream after the last block.
module sha2_compress #(
    parameter int DATA_WIDTH  = 32,
    parameter bit SUPPORT_224 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  mode_in,
    input  logic                  w_valid_in,
    input  logic [DATA_WIDTH-1:0] w_data_in,
    input  logic                  w_last_in,
    output logic                  w_ready_out,
    output logic                  d_valid_out,
    output logic [DATA_WIDTH-1:0] d_data_out,
    output logic                  d_last_out,
    input  logic                  d_ready_in,
    output logic                  busy_out
);
    import sha2_pkg::*;

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("sha2_compress: DATA_WIDTH must be 32");
    end

    sha2_state_e      state_q, state_d;
    logic [5:0]       t_q, t_d;
    logic [2:0]       idx_q, idx_d;
    sha2_mode_e       mode_q, mode_d;
    logic             last_q, last_d;
    logic [7:0][31:0] h_q, h_d;
    logic [7:0][31:0] wv_q, wv_d;

    sha2_mode_e       startMode;
    logic [7:0][31:0] ivSel;
    logic [7:0][31:0] hSum;
    logic [7:0][31:0] roundNext;
    logic             lastWord;

    sha2_round u_round (
        .state_i (wv_q),
        .k_i     (sha2_k(t_q)),
        .w_i     (w_data_in),
        .state_o (roundNext)
    );

    // Without 224 support the mode pin is ignored and every message uses the SHA-256 IV.
    always_comb begin
        startMode = (SUPPORT_224 && mode_in) ? MODE_SHA224 : MODE_SHA256;
        for (int i = 0; i < 8; i++) begin
            ivSel[i] = (startMode == MODE_SHA224) ? IV224[i] : IV256[i];
            hSum[i]  = h_q[i] + wv_q[i];
        end
        lastWord = (idx_q == ((mode_q == MODE_SHA224) ? 3'd6 : 3'd7));
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        last_d  = last_q;
        h_d     = h_q;
        wv_d    = wv_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    mode_d  = startMode;
                    h_d     = ivSel;
                    wv_d    = ivSel;
                    t_d     = 6'd0;
                    idx_d   = 3'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_valid_in) begin
                    wv_d = roundNext;
                    t_d  = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        last_d  = w_last_in;
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                // The chained hash also seeds a..h so a following block starts immediately.
                h_d     = hSum;
                wv_d    = hSum;
                t_d     = 6'd0;
                state_d = last_q ? ST_OUT : ST_ROUND;
            end
            ST_OUT: begin
                if (d_ready_in) begin
                    if (lastWord) begin
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= 6'd0;
            idx_q   <= 3'd0;
            mode_q  <= MODE_SHA256;
            last_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV256[i];
                wv_q[i] <= IV256[i];
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            h_q     <= h_d;
            wv_q    <= wv_d;
        end
    end

    always_comb begin
        w_ready_out = (state_q == ST_ROUND);
        d_valid_out = (state_q == ST_OUT);
        d_data_out  = d_valid_out ? h_q[idx_q] : '0;
        d_last_out  = d_valid_out && lastWord;
        busy_out    = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_sha2_compress.sv
// Self-checking bench for sha2_compress: a full SHA-2 software model (padding,
// schedule, compression) predicts every digest word streamed by the engine.
module tb_sha2_compress;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256_TB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV224_TB [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        mode_in;
    logic        w_valid_in;
    logic [31:0] w_data_in;
    logic        w_last_in;
    logic        w_ready_out;
    logic        d_valid_out;
    logic [31:0] d_data_out;
    logic        d_last_out;
    logic        d_ready_in;
    logic        busy_out;

    int checks = 0;
    int fails  = 0;

    byte unsigned msgBytes[$];
    logic [31:0]  schedQ[$];
    logic [31:0]  digestW[8];
    int           digestLen;
    logic [31:0]  expData[$];
    bit           expLast[$];

    sha2_compress #(.DATA_WIDTH(32), .SUPPORT_224(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .mode_in     (mode_in),
        .w_valid_in  (w_valid_in),
        .w_data_in   (w_data_in),
        .w_last_in   (w_last_in),
        .w_ready_out (w_ready_out),
        .d_valid_out (d_valid_out),
        .d_data_out  (d_data_out),
        .d_last_out  (d_last_out),
        .d_ready_in  (d_ready_in),
        .busy_out    (busy_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Software SHA-2: pads msgBytes, fills schedQ with every block's 64 words and digestW with the result.
    task automatic modelMessage(input bit is224);
        byte unsigned p[$];
        logic [63:0]  bitLen;
        logic [31:0]  w[64];
        logic [31:0]  hv[8];
        logic [31:0]  v[8];
        logic [31:0]  t1, t2, s0, s1;
        int           base;
        p = msgBytes;
        bitLen = 64'(msgBytes.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitLen[i*8 +: 8]);
        schedQ.delete();
        for (int i = 0; i < 8; i++) hv[i] = is224 ? IV224_TB[i] : IV256_TB[i];
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++) begin
                base = blk * 64 + 4 * t;
                w[t] = {p[base], p[base+1], p[base+2], p[base+3]};
            end
            for (int t = 16; t < 64; t++) begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            for (int t = 0; t < 64; t++) schedQ.push_back(w[t]);
            v = hv;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
        end
        digestW   = hv;
        digestLen = is224 ? 7 : 8;
    endtask

    task automatic loadString(input string s);
        msgBytes.delete();
        for (int i = 0; i < s.len(); i++) msgBytes.push_back(s.getc(i));
    endtask

    function automatic logic [255:0] packedDigest();
        logic [255:0] r = '0;
        for (int i = 0; i < digestLen; i++) r = {r[223:0], digestW[i]};
        return r;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs the message currently in schedQ/digestW through the engine with optional input gaps,
    // output stalls and start_in held high for the whole message.
    task automatic applyStimulus(input bit mode, input int gapPct, input int stallPct, input bit holdStart);
        int  nBlocks = schedQ.size() / 64;
        int  t, budget, got;
        bit  v, hs, isFinal, wasLast, done;
        for (int i = 0; i < digestLen; i++) begin
            expData.push_back(digestW[i]);
            expLast.push_back(i == digestLen - 1);
        end
        checkOutput("idle before start", 256'(busy_out), 256'd0);
        start_in = 1'b1;
        mode_in  = mode;
        stepCycle();
        start_in = holdStart;
        mode_in  = 1'($urandom_range(1));
        checkOutput("w_ready after start", 256'(w_ready_out), 256'd1);
        for (int b = 0; b < nBlocks; b++) begin
            isFinal = (b == nBlocks - 1);
            t = 0;
            budget = 0;
            while (t < 64 && budget < 2000) begin
                v = ($urandom_range(99) >= gapPct);
                w_valid_in = v;
                w_data_in  = v ? schedQ[b*64 + t] : $urandom;
                w_last_in  = (t == 63) ? isFinal : 1'($urandom_range(1));
                hs = v && w_ready_out;
                if (v) checkOutput("w_ready in round", 256'(w_ready_out), 256'd1);
                stepCycle();
                if (hs) t++;
                budget++;
            end
            if (t < 64) checkOutput("schedule feed timeout", 256'(t), 256'd64);
            w_valid_in = 1'b0;
            checkOutput("update w_ready", 256'(w_ready_out), 256'd0);
            checkOutput("update d_valid", 256'(d_valid_out), 256'd0);
            checkOutput("update busy", 256'(busy_out), 256'd1);
            stepCycle();
            if (isFinal) checkOutput("d_valid after update", 256'(d_valid_out), 256'd1);
            else         checkOutput("w_ready next block", 256'(w_ready_out), 256'd1);
        end
        got = 0;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            d_ready_in = ($urandom_range(99) >= stallPct);
            wasLast = d_last_out;
            hs = d_valid_out && d_ready_in;
            stepCycle();
            if (hs) begin
                got++;
                done = wasLast;
            end
        end
        d_ready_in = 1'b0;
        checkOutput("digest words streamed", 256'(got), 256'(digestLen));
        checkOutput("busy after last handshake", 256'(busy_out), 256'd0);
        start_in = 1'b0;
    endtask

    // Single compare process: digest words against the model queue, and quiet outputs when not valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid_out) begin
                if (expData.size() == 0) begin
                    checkOutput("unexpected d_valid", 256'(d_valid_out), 256'd0);
                end else begin
                    checkOutput("digest word", 256'(d_data_out), 256'(expData[0]));
                    checkOutput("d_last", 256'(d_last_out), 256'(expLast[0]));
                    if (d_ready_in) begin
                        void'(expData.pop_front());
                        void'(expLast.pop_front());
                    end
                end
            end else begin
                checkOutput("d_data while invalid", 256'(d_data_out), 256'd0);
                checkOutput("d_last while invalid", 256'(d_last_out), 256'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start_in = 1'b0; mode_in = 1'b0; w_valid_in = 1'b0;
        w_data_in = '0; w_last_in = 1'b0; d_ready_in = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset w_ready", 256'(w_ready_out), 256'd0);
        checkOutput("reset d_valid", 256'(d_valid_out), 256'd0);
        checkOutput("reset d_last", 256'(d_last_out), 256'd0);
        checkOutput("reset busy", 256'(busy_out), 256'd0);
        checkOutput("reset d_data", 256'(d_data_out), 256'd0);
        rst = 1'b0;
        stepCycle();

        loadString("abc");
        modelMessage(1'b0);
        checkOutput("model abc 256", packedDigest(),
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        applyStimulus(1'b0, 0, 0, 1'b0);

        modelMessage(1'b1);
        checkOutput("model abc 224", packedDigest(),
            256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7);
        applyStimulus(1'b1, 0, 0, 1'b0);

        loadString("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        modelMessage(1'b0);
        checkOutput("model two-block", packedDigest(),
            256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
        checkOutput("model two-block length", 256'(schedQ.size()), 256'd128);
        applyStimulus(1'b0, 0, 0, 1'b0);

        loadString("abc");
        modelMessage(1'b0);
        applyStimulus(1'b0, 50, 50, 1'b0);

        // Abort after 30 words; nothing is queued, so any digest output is flagged.
        start_in = 1'b1; mode_in = 1'b0;
        stepCycle();
        start_in = 1'b0;
        for (int t = 0; t < 30; t++) begin
            w_valid_in = 1'b1; w_data_in = schedQ[t]; w_last_in = 1'b1;
            stepCycle();
        end
        w_valid_in = 1'b0;
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort busy", 256'(busy_out), 256'd0);
        checkOutput("abort w_ready", 256'(w_ready_out), 256'd0);
        checkOutput("abort d_valid", 256'(d_valid_out), 256'd0);
        repeat (80) stepCycle();
        applyStimulus(1'b0, 0, 0, 1'b0);

        applyStimulus(1'b0, 20, 30, 1'b1);

        for (int n = 0; n < 6; n++) begin
            bit m = 1'($urandom_range(1));
            int len = $urandom_range(0, 130);
            msgBytes.delete();
            for (int i = 0; i < len; i++) msgBytes.push_back(8'($urandom));
            modelMessage(m);
            applyStimulus(m, $urandom_range(0, 60), $urandom_range(0, 60), 1'($urandom_range(1)));
        end

        repeat (3) stepCycle();
        checkOutput("leftover digest words", 256'(expData.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
